// File: rtl/stack_dat_mem.sv
// rtl/stack_dat_mem.sv - data memory with a random-access port and a downward-growing hardware stack
module stack_dat_mem #(
    parameter int W           = 8,
    parameter int AW          = 8,
    parameter int STACK_TOP   = 2**AW-1,
    parameter int STACK_LIMIT = 2**(AW-1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  dat_in,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    output logic [W-1:0]  dat_out,
    input  logic          push,
    input  logic          pop,
    output logic [W-1:0]  top_out,
    output logic [W-1:0]  pop_data,
    output logic          pop_valid,
    output logic [AW-1:0] sp,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf,
    input  logic          err_clr,
    output logic          wr_drop
);

    localparam int DEPTH = 2**AW;
    localparam logic [AW-1:0] TOP_A  = AW'(STACK_TOP);
    localparam logic [AW-1:0] FULL_A = AW'(STACK_LIMIT - 1);

    logic [W-1:0] core [0:DEPTH-1];

    logic [AW-1:0] sp_inc;
    logic          do_push;
    logic          do_pop;
    logic          do_replace;
    logic          set_ovf;
    logic          set_unf;
    logic          stack_wr;
    logic [AW-1:0] stack_wr_addr;

    assign sp_inc  = sp + 1'b1;
    assign empty   = (sp == TOP_A);
    assign full    = (sp == FULL_A);
    assign dat_out = core[addr];
    assign top_out = core[sp_inc];

    // Decode the stack operation for this cycle; push+pop on an empty stack degrades to a plain push
    always_comb begin
        do_push       = 1'b0;
        do_pop        = 1'b0;
        do_replace    = 1'b0;
        set_ovf       = 1'b0;
        set_unf       = 1'b0;
        if (push && pop) begin
            if (empty) begin
                do_push = 1'b1;
                set_unf = 1'b1;
            end else begin
                do_replace = 1'b1;
            end
        end else if (push) begin
            if (full) set_ovf = 1'b1;
            else      do_push = 1'b1;
        end else if (pop) begin
            if (empty) set_unf = 1'b1;
            else       do_pop  = 1'b1;
        end
        stack_wr      = do_push | do_replace;
        stack_wr_addr = do_replace ? sp_inc : sp;
    end

    // Single memory write port: stack writes take priority over random stores; nothing commits during reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (stack_wr)
                core[stack_wr_addr] <= dat_in;
            else if (wr_en)
                core[addr] <= dat_in;
        end
    end

    // Stack pointer, pop result, sticky error flags and dropped-store pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp        <= TOP_A;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            wr_drop   <= 1'b0;
        end else begin
            pop_valid <= do_pop | do_replace;
            if (do_pop || do_replace)
                pop_data <= core[sp_inc];
            if (do_push)
                sp <= sp - 1'b1;
            else if (do_pop)
                sp <= sp_inc;
            if (set_ovf)      ovf <= 1'b1;
            else if (err_clr) ovf <= 1'b0;
            if (set_unf)      unf <= 1'b1;
            else if (err_clr) unf <= 1'b0;
            wr_drop <= stack_wr & wr_en;
        end
    end

endmodule

// File: tb/tb_stack_dat_mem.sv
// tb/tb_stack_dat_mem.sv - scoreboard bench for stack_dat_mem
module tb_stack_dat_mem;

    logic       clk;
    logic       reset;
    logic [7:0] dat_in, dat_out, top_out, pop_data, addr, sp;
    logic       wr_en, push, pop, pop_valid, empty, full, ovf, unf, err_clr, wr_drop;

    logic [7:0] dat_in4, dat_out4, top_out4, pop_data4;
    logic [3:0] addr4, sp4;
    logic       wr_en4, push4, pop4, pop_valid4, empty4, full4, ovf4, unf4, err_clr4, wr_drop4;

    int nchk = 0;
    int nerr = 0;
    logic [7:0] exp_q[$];

    stack_dat_mem dut (
        .clk(clk), .reset(reset), .dat_in(dat_in), .wr_en(wr_en), .addr(addr),
        .dat_out(dat_out), .push(push), .pop(pop), .top_out(top_out),
        .pop_data(pop_data), .pop_valid(pop_valid), .sp(sp), .empty(empty),
        .full(full), .ovf(ovf), .unf(unf), .err_clr(err_clr), .wr_drop(wr_drop)
    );

    stack_dat_mem #(.W(8), .AW(4), .STACK_TOP(15), .STACK_LIMIT(12)) dut4 (
        .clk(clk), .reset(reset), .dat_in(dat_in4), .wr_en(wr_en4), .addr(addr4),
        .dat_out(dat_out4), .push(push4), .pop(pop4), .top_out(top_out4),
        .pop_data(pop_data4), .pop_valid(pop_valid4), .sp(sp4), .empty(empty4),
        .full(full4), .ovf(ovf4), .unf(unf4), .err_clr(err_clr4), .wr_drop(wr_drop4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    // Monitor: every pop_valid pulse must match the oldest expected pop
    always @(negedge clk) begin
        if (!reset && pop_valid) begin
            nchk++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL pop_unexpected: got pop_data %0h expected no pop_valid", pop_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (pop_data !== e) begin
                    nerr++;
                    $display("FAIL pop_data: got %0h expected %0h", pop_data, e);
                end
            end
        end
        if (!reset && pop_valid4) begin
            nchk++;
            nerr++;
            $display("FAIL pop_valid4: got 1 expected 0");
        end
    end

    initial begin
        reset = 1'b1;
        {dat_in, addr, wr_en, push, pop, err_clr} = '0;
        {dat_in4, addr4, wr_en4, push4, pop4, err_clr4} = '0;
        #1;
        chk("rst_sp", sp, 8'd255);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_pop_data", pop_data, 0);
        chk("rst_flags", {ovf, unf, wr_drop}, 0);
        chk("rst_empty_full", {empty, full}, 2'b10);
        cyc; cyc;
        reset = 1'b0;

        // push A1, B2 then pop
        push = 1; dat_in = 8'hA1; cyc;
        chk("push1_sp", sp, 8'd254);
        dat_in = 8'hB2; cyc; push = 0;
        chk("push2_sp", sp, 8'd253);
        chk("push2_top", top_out, 8'hB2);
        pop = 1; exp_q.push_back(8'hB2); cyc; pop = 0;
        chk("pop1_sp", sp, 8'd254);
        pop = 1; exp_q.push_back(8'hA1); cyc; pop = 0;
        chk("pop2_sp", sp, 8'd255);
        chk("pop2_empty", empty, 1);

        // underflow, push+pop while empty, err_clr
        pop = 1; cyc; pop = 0;
        chk("unf_set", unf, 1);
        chk("unf_sp", sp, 8'd255);
        push = 1; pop = 1; dat_in = 8'h3C; cyc; push = 0; pop = 0;
        addr = 8'd255; #1;
        chk("pp_empty_sp", sp, 8'd254);
        chk("pp_empty_unf", unf, 1);
        chk("pp_empty_core255", dat_out, 8'h3C);
        err_clr = 1; cyc; err_clr = 0;
        chk("err_clr_unf", unf, 0);

        // replace top
        pop = 1; exp_q.push_back(8'h3C); cyc; pop = 0;
        push = 1; dat_in = 8'h11; cyc; push = 0;
        chk("top_11", top_out, 8'h11);
        push = 1; pop = 1; dat_in = 8'h22; exp_q.push_back(8'h11); cyc; push = 0; pop = 0;
        chk("replace_sp", sp, 8'd254);
        chk("replace_top", top_out, 8'h22);

        // random store vs stack write collision
        wr_en = 1; addr = 8'd60; dat_in = 8'h55; cyc; wr_en = 0;
        chk("store_55", dat_out, 8'h55);
        chk("store_no_drop", wr_drop, 0);
        wr_en = 1; push = 1; dat_in = 8'h10; cyc; wr_en = 0; push = 0;
        chk("drop_pulse", wr_drop, 1);
        chk("drop_core60", dat_out, 8'h55);
        chk("drop_sp", sp, 8'd253);
        wr_en = 1; dat_in = 8'h10; cyc; wr_en = 0;
        chk("store_10", dat_out, 8'h10);
        chk("drop_clear", wr_drop, 0);

        // drain, then err_clr racing a new underflow
        pop = 1; exp_q.push_back(8'h10); cyc;
        exp_q.push_back(8'h22); cyc; pop = 0;
        chk("drain_empty", empty, 1);
        pop = 1; cyc;
        chk("unf_again", unf, 1);
        err_clr = 1; cyc; pop = 0;
        chk("set_beats_clr", unf, 1);
        cyc; err_clr = 0;
        chk("clr_after", unf, 0);
        chk("ovf_never", ovf, 0);

        // asynchronous reset mid-push
        pop = 1; cyc; pop = 0;
        push = 1; dat_in = 8'h77; cyc;
        chk("pre_rst_sp", sp, 8'd254);
        dat_in = 8'h88; #1;
        reset = 1; #1;
        chk("async_sp", sp, 8'd255);
        chk("async_flags", {ovf, unf, wr_drop, pop_valid}, 0);
        cyc; cyc;
        reset = 0; push = 0;
        addr = 8'd255; #1;
        chk("keep_core255", dat_out, 8'h77);
        addr = 8'd254; #1;
        chk("keep_core254", dat_out, 8'h10);

        // small instance: fill to limit, then overflow
        wr_en4 = 1; addr4 = 4'd11; dat_in4 = 8'h5A; cyc; wr_en4 = 0;
        for (int i = 1; i <= 4; i++) begin
            push4 = 1; dat_in4 = 8'(i); cyc;
        end
        push4 = 0; #1;
        chk("fill_full", full4, 1);
        chk("fill_sp", sp4, 4'd11);
        push4 = 1; dat_in4 = 8'h99; cyc; push4 = 0; #1;
        chk("ovf_set", ovf4, 1);
        chk("ovf_sp", sp4, 4'd11);
        chk("ovf_core11", dat_out4, 8'h5A);
        chk("ovf_top", top_out4, 8'h04);

        cyc; cyc;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
